// File: rtl/s4_flatten_buffer.sv
// S4 flatten buffer: collects NUM_POS positions of NUM_CH c3 maxpool bytes and streams them
// channel-major over a valid/ready byte port. Optional S4_OVF_DETECT_EN adds a sticky dropped-input flag.
module s4_flatten_buffer #(
  parameter int NUM_POS = 25,
  parameter int NUM_CH  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       c3_mp_out_valid,
  input  logic [7:0] c3_mp_out_ch_0,
  input  logic [7:0] c3_mp_out_ch_1,
  input  logic [7:0] c3_mp_out_ch_2,
  input  logic [7:0] c3_mp_out_ch_3,
  input  logic [7:0] c3_mp_out_ch_4,
  input  logic [7:0] c3_mp_out_ch_5,
  input  logic [7:0] c3_mp_out_ch_6,
  input  logic [7:0] c3_mp_out_ch_7,
  input  logic [7:0] c3_mp_out_ch_8,
  input  logic [7:0] c3_mp_out_ch_9,
  input  logic [7:0] c3_mp_out_ch_10,
  input  logic [7:0] c3_mp_out_ch_11,
  input  logic [7:0] c3_mp_out_ch_12,
  input  logic [7:0] c3_mp_out_ch_13,
  input  logic [7:0] c3_mp_out_ch_14,
  input  logic [7:0] c3_mp_out_ch_15,
  output logic       s4_out_valid,
  input  logic       s4_out_ready,
  output logic [7:0] s4_out_data,
  output logic [8:0] s4_out_index,
  output logic       s4_out_last,
  output logic       frame_done,
  output logic       busy,
  output logic       overflow_err
);
  localparam int POS_W = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TOTAL = NUM_POS * NUM_CH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [15:0][7:0]        ch_in;
  logic [NUM_CH*8-1:0]     wr_word;
  logic [NUM_CH*8-1:0]     buf_q [NUM_POS];

  logic [1:0]       state_q, state_d;
  logic [POS_W-1:0] wr_pos_q, wr_pos_d;
  logic [POS_W-1:0] rd_pos_q, rd_pos_d;
  logic [CH_W-1:0]  rd_ch_q, rd_ch_d;
  logic [8:0]       rd_idx_q, rd_idx_d;
  logic             issued_q, issued_d;
  logic             prime_q, prime_d;
  logic             vld_q, vld_d;
  logic [7:0]       data_q, data_d;
  logic [8:0]       idx_q, idx_d;
  logic             last_q, last_d;
  logic             fdone_q, fdone_d;
  logic             wr_en, hs, load;
  logic [7:0]       rd_byte;

  assign ch_in = {c3_mp_out_ch_15, c3_mp_out_ch_14, c3_mp_out_ch_13, c3_mp_out_ch_12,
                  c3_mp_out_ch_11, c3_mp_out_ch_10, c3_mp_out_ch_9,  c3_mp_out_ch_8,
                  c3_mp_out_ch_7,  c3_mp_out_ch_6,  c3_mp_out_ch_5,  c3_mp_out_ch_4,
                  c3_mp_out_ch_3,  c3_mp_out_ch_2,  c3_mp_out_ch_1,  c3_mp_out_ch_0};

  for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
    assign wr_word[k*8 +: 8] = ch_in[k];
  end

  assign wr_en   = c3_mp_out_valid && (state_q == IDLE || state_q == FILL);
  assign hs      = vld_q && s4_out_ready;
  // prime_q spends the first DRAIN cycle idle so the first byte appears two edges after the last write
  assign load    = (state_q == DRAIN) && prime_q && !issued_q && (!vld_q || s4_out_ready);
  assign rd_byte = buf_q[rd_pos_q][{rd_ch_q, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_pos_q] <= wr_word;
  end

  always_comb begin
    state_d  = state_q;
    wr_pos_d = wr_pos_q;
    rd_pos_d = rd_pos_q;
    rd_ch_d  = rd_ch_q;
    rd_idx_d = rd_idx_q;
    issued_d = issued_q;
    prime_d  = prime_q;
    vld_d    = vld_q;
    data_d   = data_q;
    idx_d    = idx_q;
    last_d   = last_q;
    fdone_d  = 1'b0;
    case (state_q)
      IDLE, FILL: begin
        if (wr_en) begin
          state_d  = FILL;
          wr_pos_d = wr_pos_q + 1'b1;
          if (wr_pos_q == POS_W'(NUM_POS - 1)) begin
            state_d  = DRAIN;
            wr_pos_d = '0;
          end
        end
      end
      DRAIN: begin
        prime_d = 1'b1;
        if (load) begin
          vld_d    = 1'b1;
          data_d   = rd_byte;
          idx_d    = rd_idx_q;
          last_d   = (rd_idx_q == 9'(TOTAL - 1));
          rd_idx_d = rd_idx_q + 9'd1;
          issued_d = (rd_idx_q == 9'(TOTAL - 1));
          if (rd_pos_q == POS_W'(NUM_POS - 1)) begin
            rd_pos_d = '0;
            rd_ch_d  = rd_ch_q + 1'b1;
          end else begin
            rd_pos_d = rd_pos_q + 1'b1;
          end
        end else if (hs) begin
          vld_d = 1'b0;
          if (last_q) begin
            state_d  = DONE;
            fdone_d  = 1'b1;
            rd_pos_d = '0;
            rd_ch_d  = '0;
            rd_idx_d = '0;
            issued_d = 1'b0;
            prime_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_pos_q <= '0;
      rd_pos_q <= '0;
      rd_ch_q  <= '0;
      rd_idx_q <= '0;
      issued_q <= 1'b0;
      prime_q  <= 1'b0;
      vld_q    <= 1'b0;
      data_q   <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_pos_q <= wr_pos_d;
      rd_pos_q <= rd_pos_d;
      rd_ch_q  <= rd_ch_d;
      rd_idx_q <= rd_idx_d;
      issued_q <= issued_d;
      prime_q  <= prime_d;
      vld_q    <= vld_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      fdone_q  <= fdone_d;
    end
  end

  assign s4_out_valid = vld_q;
  assign s4_out_data  = data_q;
  assign s4_out_index = idx_q;
  assign s4_out_last  = last_q;
  assign frame_done   = fdone_q;
  assign busy         = (state_q != IDLE);

`ifdef S4_OVF_DETECT_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (c3_mp_out_valid && (state_q == DRAIN || state_q == DONE)) ovf_q <= 1'b1;
  end
  assign overflow_err = ovf_q;
`else
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_s4_flatten_buffer.sv
// Bench for s4_flatten_buffer: scenario table plus a frame-array reference model of the flattened stream.
module tb_s4_flatten_buffer;
  logic       clk = 1'b0;
  logic       rst_n, in_v, ready;
  logic [7:0] ch [16];
  logic       valid, last, fdone, busy, ovf;
  logic [7:0] data;
  logic [8:0] index;

  always #5 clk = ~clk;

  s4_flatten_buffer dut (
    .clk(clk), .rst_n(rst_n), .c3_mp_out_valid(in_v),
    .c3_mp_out_ch_0(ch[0]),   .c3_mp_out_ch_1(ch[1]),   .c3_mp_out_ch_2(ch[2]),   .c3_mp_out_ch_3(ch[3]),
    .c3_mp_out_ch_4(ch[4]),   .c3_mp_out_ch_5(ch[5]),   .c3_mp_out_ch_6(ch[6]),   .c3_mp_out_ch_7(ch[7]),
    .c3_mp_out_ch_8(ch[8]),   .c3_mp_out_ch_9(ch[9]),   .c3_mp_out_ch_10(ch[10]), .c3_mp_out_ch_11(ch[11]),
    .c3_mp_out_ch_12(ch[12]), .c3_mp_out_ch_13(ch[13]), .c3_mp_out_ch_14(ch[14]), .c3_mp_out_ch_15(ch[15]),
    .s4_out_valid(valid), .s4_out_ready(ready), .s4_out_data(data), .s4_out_index(index),
    .s4_out_last(last), .frame_done(fdone), .busy(busy), .overflow_err(ovf)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] model [25][16];
  bit         ovf_exp  = 1'b0;

  typedef struct {
    int dmode;      // 0: byte = pos*16+ch, 1: random bytes
    int gap;        // random idle cycles between strobes
    int rmode;      // 0: ready=1, 1: ready 1,0,0 repeating, 2: random ready
    int inj_at;     // beat at which a stray strobe arrives (-1 none)
    int rst_at;     // beat at which reset pulses (-1 none)
    bit done_inj;   // stray strobe during the DONE cycle
    bit b2b;        // start this frame right after the previous frame_done
    int exp_beats;
  } scen_t;
  scen_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input int dmode, input int gap);
    for (int p = 0; p < 25; p++) begin
      if (gap != 0) repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_v = 1'b0;
      end
      @(negedge clk);
      if (p == 0) begin
        chk("idle_before_fill", 32'(busy), 32'd0);
        chk("no_frame_done_idle", 32'(fdone), 32'd0);
      end
      for (int j = 0; j < 16; j++) begin
        model[p][j] = (dmode != 0) ? 8'($urandom) : 8'(p * 16 + j);
        ch[j] = model[p][j];
      end
      in_v = 1'b1;
    end
    @(negedge clk);
    in_v = 1'b0;
  endtask

  task automatic drain(input int rmode, input int inj_at, input int rst_at, input bit done_inj,
                       output int beats);
    bit seen, held, injd;
    int k;
    logic [7:0] hd;
    logic [8:0] hi;
    logic       hl;
    beats = 0; seen = 0; held = 0; injd = 0; k = 0;
    hd = '0; hi = '0; hl = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (n > 0) @(negedge clk);
      in_v = 1'b0;
      if (beats == 400) begin
        chk("valid_after_last", 32'(valid), 32'd0);
        chk("frame_done_pulse", 32'(fdone), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd1);
        chk("overflow_flag", 32'(ovf), 32'(ovf_exp));
        if (done_inj) begin
          for (int j = 0; j < 16; j++) ch[j] = 8'($urandom);
          in_v = 1'b1;
`ifdef S4_OVF_DETECT_EN
          ovf_exp = 1'b1;
`endif
          @(negedge clk);
          in_v = 1'b0;
          chk("frame_done_one_cycle", 32'(fdone), 32'd0);
          chk("idle_after_done", 32'(busy), 32'd0);
        end
        return;
      end
      if (held) begin
        chk("stall_valid", 32'(valid), 32'd1);
        chk("stall_data", 32'(data), 32'(hd));
        chk("stall_index", 32'(index), 32'(hi));
        chk("stall_last", 32'(last), 32'(hl));
      end
      if (!seen && valid) begin
        seen = 1;
        chk("first_valid_latency", 32'(n), 32'd2);
        chk("first_index", 32'(index), 32'd0);
      end
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = seen ? (k % 3 == 0) : 1'b1;
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (seen) k++;
      if (rst_at >= 0 && beats == rst_at && valid) begin
        rst_n = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'({valid, data, index, last, fdone, busy, ovf}), 32'd0);
        rst_n   = 1'b1;
        ovf_exp = 1'b0;
        return;
      end
      if (inj_at >= 0 && beats == inj_at && valid && !injd) begin
        injd = 1;
        for (int j = 0; j < 16; j++) ch[j] = 8'($urandom);
        in_v = 1'b1;
`ifdef S4_OVF_DETECT_EN
        ovf_exp = 1'b1;
`endif
      end
      if (valid && ready) begin
        chk("beat_data", 32'(data), 32'(model[beats % 25][beats / 25]));
        chk("beat_index", 32'(index), 32'(beats));
        chk("beat_last", 32'(last), 32'(beats == 399));
        beats++;
        held = 0;
      end else if (valid) begin
        held = 1; hd = data; hi = index; hl = last;
      end else begin
        held = 0;
      end
    end
    chk("drain_timeout", 32'(beats), 32'd400);
  endtask

  initial begin
    int beats;
    tbl[0] = '{0, 0, 0, -1,  -1, 0, 0, 400};
    tbl[1] = '{0, 0, 1, -1,  -1, 0, 0, 400};
    tbl[2] = '{1, 1, 2, 100, -1, 0, 0, 400};
    tbl[3] = '{0, 0, 0, -1, 200, 0, 0, 200};
    tbl[4] = '{1, 0, 0, -1,  -1, 0, 0, 400};
    tbl[5] = '{1, 0, 1, -1,  -1, 0, 1, 400};
    tbl[6] = '{1, 1, 2, -1,  -1, 1, 0, 400};
    tbl[7] = '{1, 0, 2, -1,  -1, 0, 1, 400};

    rst_n = 1'b0; in_v = 1'b0; ready = 1'b0;
    for (int j = 0; j < 16; j++) ch[j] = '0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_data", 32'(data), 32'd0);
    chk("reset_index", 32'(index), 32'd0);
    chk("reset_last", 32'(last), 32'd0);
    chk("reset_frame_done", 32'(fdone), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_overflow", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    for (int s = 0; s < 8; s++) begin
      if (!tbl[s].b2b) repeat (3) @(negedge clk);
      send_frame(tbl[s].dmode, tbl[s].gap);
      drain(tbl[s].rmode, tbl[s].inj_at, tbl[s].rst_at, tbl[s].done_inj, beats);
      chk($sformatf("scen%0d_beat_count", s), 32'(beats), 32'(tbl[s].exp_beats));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/s4_flatten_buffer.md
S4_FLATTEN_BUFFER -- requirements
Module: s4_flatten_buffer

Interface
REQ-001 The block SHALL have parameter NUM_POS, default 25, the number of spatial positions (5x5) per frame.
REQ-002 The block SHALL have parameter NUM_CH, default 16, the number of c3 maxpool channels per position.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port c3_mp_out_valid  input  1  a one-cycle strobe marking one valid position.
REQ-006 The block SHALL have ports c3_mp_out_ch_0 .. c3_mp_out_ch_15  input  8 each  the unsigned channel bytes for that position.
REQ-007 The block SHALL have port s4_out_valid  output  1  flattened byte available.
REQ-008 The block SHALL have port s4_out_ready  input  1  downstream FC layer accepts the byte.
REQ-009 The block SHALL have port s4_out_data  output  8  the flattened byte.
REQ-010 The block SHALL have port s4_out_index  output  9  the flat index of s4_out_data, 0..399.
REQ-011 The block SHALL have port s4_out_last  output  1  high together with index 399.
REQ-012 The block SHALL have port frame_done  output  1  a one-cycle pulse after the final handshake.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 The block SHALL have port overflow_err  output  1  sticky flag for input dropped during drain.

Function
REQ-015 The block SHALL use FSM states IDLE, FILL, DRAIN and DONE.
REQ-016 Each c3_mp_out_valid in IDLE or FILL SHALL write the 16 channel bytes to buffer entry wr_pos, then increment wr_pos; the first write moves IDLE to FILL.
REQ-017 The write with wr_pos == NUM_POS-1 SHALL move the FSM to DRAIN and clear wr_pos to 0.
REQ-018 The flat order SHALL be channel-major: index = ch*NUM_POS + pos, so ch0 covers pos 0..24, then ch1, and so on.
REQ-019 s4_out_valid SHALL first rise exactly 2 cycles after the clock edge of the 25th write, with index 0.
REQ-020 s4_out_data, s4_out_index and s4_out_last SHALL be registered and held stable while s4_out_valid=1 and s4_out_ready=0.
REQ-021 Each cycle with s4_out_valid=1 and s4_out_ready=1 SHALL be a handshake; the next index SHALL be presented on the following cycle, giving 1 byte per cycle while ready stays high.
REQ-022 s4_out_valid SHALL NOT depend combinationally on s4_out_ready.
REQ-023 The handshake at index 399 SHALL deassert s4_out_valid on the next cycle and move the FSM to DONE.
REQ-024 DONE SHALL last exactly 1 cycle with frame_done=1, then return to IDLE.
REQ-025 c3_mp_out_valid received in DRAIN or DONE SHALL be dropped, leaving the buffer and counters unchanged.
REQ-026 c3_mp_out_valid in the same cycle that DONE returns to IDLE SHALL be dropped.
REQ-027 The buffer SHALL hold NUM_POS entries of NUM_CH*8 bits; the read index SHALL wrap pos 24 to 0 while incrementing ch.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL force state=IDLE and set wr_pos, read counters, s4_out_valid, s4_out_data, s4_out_index, s4_out_last, frame_done, busy and overflow_err to 0.
REQ-029 Reset asserted in any state, including mid-FILL or mid-DRAIN, SHALL abort the frame with no frame_done pulse; buffer contents need not be cleared.

Configuration
REQ-030 With macro S4_OVF_DETECT_EN defined, any dropped input per REQ-025/026 SHALL set overflow_err to 1, held until reset.
REQ-031 Without S4_OVF_DETECT_EN, overflow_err SHALL be constant 0 and no detection logic SHALL be synthesized; the port SHALL remain present.

Verification
REQ-032 Feed 25 strobes with ch_k = pos*16+k (mod 256), ready held 1 -> 400 consecutive beats; beat i carries (i%25)*16 + i/25 (mod 256); last=1 only at 399; frame_done pulses 1 cycle after beat 399.
REQ-033 Same frame with ready toggled 1,0,0 repeating -> identical data sequence; data, index and last stay stable while stalled.
REQ-034 Latency check: the 25th strobe on edge T -> s4_out_valid rises at T+2 with index 0.
REQ-035 With S4_OVF_DETECT_EN defined, inject a strobe at drain index 100 -> overflow_err=1 and the output sequence unchanged; without the macro, overflow_err stays 0.
REQ-036 Assert rst_n=0 for 1 cycle at drain index 200 -> all outputs 0 and IDLE; a new 25-strobe frame then drains correctly from index 0.
REQ-037 Drive back-to-back frames, with frame 2's first strobe on the cycle after frame_done -> frame 2 is accepted and drained correctly.
